fnd_scan_controller: RTL

- Parametrised multi-digit 7-segment (FND) display controller.
- Converts a binary value to BCD sequentially (shift-add-3), latches the result into a display register, and time-multiplexes NUM_DIGITS common-anode digits.
- Adds leading-zero blanking, per-digit decimal points and overflow indication.
- Sits between arithmetic datapaths (adder, counter) and the board FND pins.

---
 rtl/fnd_scan_controller.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fnd_scan_controller.sv
// Multi-digit common-anode 7-segment scan controller: sequential binary-to-BCD
// conversion (shift-add-3), latched display register, digit multiplexing.
`timescale 1ns/1ps
module fnd_scan_controller #(
    parameter int IN_WIDTH   = 14,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   bin_in,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic [NUM_DIGITS-1:0] fnd_com,
    output logic [7:0]            fnd_data,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [1:0]            dbg_state
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   sh_q, sh_d;
    logic [IN_WIDTH-1:0]   val_q, val_d;
    logic [IN_WIDTH-1:0]   last_q, last_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [BCD_W-1:0]      bcd_adj;
    logic [4:0]            step_q, step_d;
    logic                  force_q, force_d;
    logic [BCD_W-1:0]      disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] com_q, com_d;
    logic [7:0]            data_q, data_d;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_lz;
    logic                  zero_run;

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7f;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            val_q   <= '0;
            last_q  <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            force_q <= 1'b1;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            com_q   <= '1;
            data_q  <= 8'hff;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            val_q   <= val_d;
            last_q  <= last_d;
            bcd_q   <= bcd_d;
            step_q  <= step_d;
            force_q <= force_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            com_q   <= com_d;
            data_q  <= data_d;
        end
    end

    // Conversion FSM: inputs changing mid-conversion are caught on return to
    // IDLE by comparison with the last converted value.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        val_d   = val_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        step_d  = step_q;
        force_d = force_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        bcd_adj = bcd_q;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (bcd_q[4*j +: 4] >= 4'd5) begin
                bcd_adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (force_q || (bin_in != last_q)) begin
                    sh_d    = bin_in;
                    val_d   = bin_in;
                    bcd_d   = '0;
                    step_d  = '0;
                    force_d = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d  = {bcd_adj[BCD_W-2:0], sh_q[IN_WIDTH-1]};
                sh_d   = sh_q << 1;
                step_d = step_q + 5'd1;
                if (step_q == 5'(IN_WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                disp_d  = bcd_q;
                last_d  = val_q;
                ovf_d   = (32'(val_q) > MAX_VAL);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Walk from the most significant digit down so zero_run tells whether the
    // selected digit and everything above it are zero.
    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_lz   = 1'b0;
        zero_run = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            zero_run = zero_run & (disp_q[4*j +: 4] == 4'd0);
            if (idx_q == IDX_W'(j)) begin
                cur_nib = disp_q[4*j +: 4];
                cur_dp  = dp_in[j];
                cur_lz  = zero_run && (j != 0);
            end
        end
        com_d = ~(NUM_DIGITS'(1) << idx_q);
        if (ovf_q) begin
            data_d = {1'b1, 7'h3f};
        end else if (blank_lz && cur_lz) begin
            data_d = {~cur_dp, 7'h7f};
        end else begin
            data_d = {~cur_dp, seg_code(cur_nib)};
        end
    end

    assign fnd_com   = com_q;
    assign fnd_data  = data_q;
    assign busy      = (state_q != S_IDLE);
    assign bcd_valid = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule
